// File: rtl/flasher_state_datapath.sv
// Sequential datapath for the bound flasher: holds the registered main state and the
// 5-bit LED counter, applies the generator's load/up/down/hold commands, synchronises
// the flick button, produces kickback_match and decodes the counter onto the LED bar.
// Optional build macro STEP_PRESCALER_EN: steps only on a divided tick and latches flick
// between ticks so that short presses are not lost.
module flasher_state_datapath #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned PRESCALE_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flick_async,
  input  logic [2:0]  main_state_n,
  input  logic [4:0]  counter_load,
  input  logic        counter_load_en,
  input  logic [1:0]  count_state,
  output logic [2:0]  main_state,
  output logic [4:0]  counter,
  output logic        flick,
  output logic        kickback_match,
  output logic [15:0] led,
  output logic        busy
);

  // Main-state codes shared with the generator.
  localparam logic [2:0] InitState  = 3'd0;
  localparam logic [2:0] OffLed15_5 = 3'd2;
  localparam logic [2:0] OffLed10_0 = 3'd4;
  localparam logic [2:0] IllegalSt  = 3'd7;

  // Count commands; 2'b11 falls through to hold.
  localparam logic [1:0] CountUpEn   = 2'b01;
  localparam logic [1:0] CountDownEn = 2'b10;

  // Reject out-of-range parameters at elaboration.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || PRESCALE_DIV < 2 || PRESCALE_DIV > 65536)
  begin : gen_param_check
    $error("flasher_state_datapath: parameter out of range");
  end

  logic [2:0]             state_q, state_d;
  logic [4:0]             counter_q, counter_d;
  logic [15:0]            led_q, led_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   step;

  // Flick synchroniser: shift the raw button through SYNC_STAGES flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], flick_async};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef STEP_PRESCALER_EN
  logic [15:0] div_q, div_d;
  logic        tick;
  logic        sync_prev_q;
  logic        flick_q, flick_d;
  logic        flick_rise;

  assign tick       = (div_q == 16'(PRESCALE_DIV - 1));
  assign flick_rise = sync_out & ~sync_prev_q;

  // Divider next value and sticky flick: a tick consumes the latched press, but a rise
  // arriving on that same edge is kept for the following tick.
  always_comb begin
    div_d   = tick ? 16'd0 : div_q + 16'd1;
    flick_d = tick ? flick_rise : (flick_q | flick_rise);
  end

  // Free-running divider and flick latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q       <= 16'd0;
      sync_prev_q <= 1'b0;
      flick_q     <= 1'b0;
    end else begin
      div_q       <= div_d;
      sync_prev_q <= sync_out;
      flick_q     <= flick_d;
    end
  end

  assign step  = tick;
  assign flick = flick_q;
`else
  assign step  = 1'b1;
  assign flick = sync_out;
`endif

  // Next state/counter from the generator's commands; LEDs decode the next counter so
  // they land in the same cycle as the counter itself.
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    led_d     = '0;
    if (step) begin
      state_d = (main_state_n == IllegalSt) ? InitState : main_state_n;
      if (counter_load_en) begin
        counter_d = counter_load;
      end else begin
        case (count_state)
          CountUpEn: begin
            if (counter_q != 5'd31) counter_d = counter_q + 5'd1;
          end
          CountDownEn: begin
            if (counter_q != 5'd0) counter_d = counter_q - 5'd1;
          end
          default: counter_d = counter_q;
        endcase
      end
    end
    for (int i = 0; i < 16; i++) begin
      led_d[i] = (i < int'(counter_d));
    end
  end

  // State, counter and LED registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= InitState;
      counter_q <= 5'd0;
      led_q     <= 16'h0000;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      led_q     <= led_d;
    end
  end

  // Outputs fed back to the generator and the board.
  always_comb begin
    main_state     = state_q;
    counter        = counter_q;
    led            = led_q;
    busy           = (state_q != InitState);
    kickback_match = flick & (((state_q == OffLed15_5) && (counter_q == 5'd5)) ||
                              ((state_q == OffLed10_0) && (counter_q == 5'd0)));
  end

endmodule

// File: tb/tb_flasher_state_datapath.sv
// Directed bench for flasher_state_datapath. A small bound-flasher generator can be
// switched into the loop; otherwise the generator-side inputs are driven directly.
module tb_flasher_state_datapath;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flick_async;
  logic [2:0]  main_state_n;
  logic [4:0]  counter_load;
  logic        counter_load_en;
  logic [1:0]  count_state;
  logic [2:0]  main_state;
  logic [4:0]  counter;
  logic        flick;
  logic        kickback_match;
  logic [15:0] led;
  logic        busy;

  logic        use_gen;
  logic [2:0]  d_state_n, g_state_n;
  logic [4:0]  d_load, g_load;
  logic        d_load_en, g_load_en;
  logic [1:0]  d_count, g_count;

  int n_tests = 0;
  int n_fail  = 0;

  flasher_state_datapath #(
    .SYNC_STAGES  (2),
    .PRESCALE_DIV (4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flick_async     (flick_async),
    .main_state_n    (main_state_n),
    .counter_load    (counter_load),
    .counter_load_en (counter_load_en),
    .count_state     (count_state),
    .main_state      (main_state),
    .counter         (counter),
    .flick           (flick),
    .kickback_match  (kickback_match),
    .led             (led),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // Reference bound-flasher generator (stimulus source when use_gen = 1).
  always_comb begin
    g_state_n = main_state;
    g_load    = 5'd0;
    g_load_en = 1'b0;
    g_count   = 2'b00;
    case (main_state)
      3'd0: if (flick) begin g_state_n = 3'd1; g_count = 2'b01; end
      3'd1: if (counter == 5'd16) g_state_n = 3'd2; else g_count = 2'b01;
      3'd2: begin
        if (kickback_match) begin g_load = 5'd16; g_load_en = 1'b1; end
        else if (counter == 5'd5) g_state_n = 3'd3;
        else g_count = 2'b10;
      end
      3'd3: if (counter == 5'd11) g_state_n = 3'd4; else g_count = 2'b01;
      3'd4: begin
        if (kickback_match) begin g_load = 5'd11; g_load_en = 1'b1; end
        else if (counter == 5'd0) g_state_n = 3'd5;
        else g_count = 2'b10;
      end
      3'd5: if (counter == 5'd6) g_state_n = 3'd6; else g_count = 2'b01;
      3'd6: if (counter == 5'd0) g_state_n = 3'd0; else g_count = 2'b10;
      default: g_state_n = 3'd0;
    endcase
  end

  assign main_state_n    = use_gen ? g_state_n : d_state_n;
  assign counter_load    = use_gen ? g_load    : d_load;
  assign counter_load_en = use_gen ? g_load_en : d_load_en;
  assign count_state     = use_gen ? g_count   : d_count;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] led_model(input logic [4:0] c);
    logic [15:0] m;
    for (int i = 0; i < 16; i++) m[i] = (i < int'(c));
    return m;
  endfunction

  // Expected (state, counter) seen right after each state change of a full flash.
  logic [2:0] exp_state [6];
  logic [4:0] exp_cnt   [6];

  initial begin
    exp_state = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0};
    exp_cnt   = '{5'd16, 5'd5, 5'd11, 5'd0, 5'd6, 5'd0};
    rst_n       = 1'b0;
    flick_async = 1'b0;
    use_gen     = 1'b1;
    d_state_n   = 3'd0;
    d_load      = 5'd0;
    d_load_en   = 1'b0;
    d_count     = 2'b00;
    step();
    step();
    chk("rst_state", 32'(main_state), 0);
    chk("rst_counter", 32'(counter), 0);
    chk("rst_led", 32'(led), 0);
    chk("rst_flick", 32'(flick), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;

`ifdef STEP_PRESCALER_EN
    // Counter steps only every 4th cycle; a 1-cycle flick between ticks is latched.
    use_gen   = 1'b0;
    d_state_n = 3'd1;
    d_count   = 2'b01;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("pre_counter", 32'(counter), 32'(k / 4));
      if (k == 8) flick_async = 1'b1;
      if (k == 9) flick_async = 1'b0;
      if (k == 10) chk("pre_flick_pending", 32'(flick), 0);
      if (k == 11) chk("pre_flick_latched", 32'(flick), 1);
      if (k == 12) chk("pre_flick_consumed", 32'(flick), 0);
    end
`else
    begin
      int idx;
      logic [2:0] prev;
      // Sync latency with the generator in the loop, flowing into a full flash.
      step();
      flick_async = 1'b1;
      step();
      chk("sync_lat1", 32'(flick), 0);
      step();
      chk("sync_lat2", 32'(flick), 1);
      chk("sync_state_init", 32'(main_state), 0);
      step();
      flick_async = 1'b0;
      chk("start_state", 32'(main_state), 1);
      chk("start_counter", 32'(counter), 1);
      chk("start_led", 32'(led), 32'h0001);
      chk("start_busy", 32'(busy), 1);

      idx  = 0;
      prev = main_state;
      for (int c = 0; c < 200; c++) begin
        step();
        chk("led_decode", 32'(led), 32'(led_model(counter)));
        chk("no_kickback", 32'(kickback_match), 0);
        if (main_state != prev) begin
          if (idx < 6) begin
            chk("flash_state", 32'(main_state), 32'(exp_state[idx]));
            chk("flash_counter", 32'(counter), 32'(exp_cnt[idx]));
          end
          if (idx == 0) chk("led_peak", 32'(led), 32'hFFFF);
          if (idx == 1) chk("led_at5", 32'(led), 32'h001F);
          idx++;
          prev = main_state;
          if (main_state == 3'd0) break;
        end
      end
      chk("flash_transitions", idx, 6);
      chk("flash_end_busy", 32'(busy), 0);

      // Kickback at 5: place state 2 / counter 7, raise flick, then run the generator.
      use_gen     = 1'b0;
      d_state_n   = 3'd2;
      d_load      = 5'd7;
      d_load_en   = 1'b1;
      d_count     = 2'b00;
      flick_async = 1'b1;
      step();
      d_load_en = 1'b0;
      step();
      step();
      chk("kb5_flick", 32'(flick), 1);
      chk("kb5_setup", 32'(counter), 7);
      use_gen = 1'b1;
      step();
      chk("kb5_at6", 32'(kickback_match), 0);
      step();
      chk("kb5_counter5", 32'(counter), 5);
      chk("kb5_match", 32'(kickback_match), 1);
      step();
      chk("kb5_reload", 32'(counter), 16);
      chk("kb5_state", 32'(main_state), 2);

      // Kickback at 0 in OFFLED10_0.
      use_gen   = 1'b0;
      d_state_n = 3'd4;
      d_load    = 5'd2;
      d_load_en = 1'b1;
      step();
      d_load_en = 1'b0;
      use_gen   = 1'b1;
      step();
      chk("kb0_at1", 32'(kickback_match), 0);
      step();
      chk("kb0_counter0", 32'(counter), 0);
      chk("kb0_match", 32'(kickback_match), 1);
      step();
      chk("kb0_reload", 32'(counter), 11);
      chk("kb0_state", 32'(main_state), 4);
      use_gen     = 1'b0;
      flick_async = 1'b0;
    end

    // Saturation, command priority and the illegal state code.
    d_state_n = 3'd1;
    d_load    = 5'd30;
    d_load_en = 1'b1;
    d_count   = 2'b00;
    step();
    d_load_en = 1'b0;
    d_count   = 2'b01;
    step();
    chk("up_to31", 32'(counter), 31);
    step();
    chk("up_sat31", 32'(counter), 31);
    chk("led_sat", 32'(led), 32'hFFFF);
    d_count = 2'b11;
    step();
    chk("cmd11_hold", 32'(counter), 31);
    d_count   = 2'b01;
    d_load    = 5'd3;
    d_load_en = 1'b1;
    step();
    chk("load_over_up", 32'(counter), 3);
    chk("led_3", 32'(led), 32'h0007);
    d_load    = 5'd1;
    d_count   = 2'b10;
    step();
    d_load_en = 1'b0;
    step();
    chk("down_to0", 32'(counter), 0);
    step();
    chk("down_sat0", 32'(counter), 0);
    d_state_n = 3'd3;
    d_count   = 2'b00;
    step();
    chk("state3", 32'(main_state), 3);
    chk("busy3", 32'(busy), 1);
    d_state_n = 3'd7;
    step();
    chk("illegal_to_init", 32'(main_state), 0);
    chk("illegal_busy", 32'(busy), 0);

    // Mid-run asynchronous reset at counter 9.
    d_state_n = 3'd1;
    d_load    = 5'd9;
    d_load_en = 1'b1;
    step();
    d_load_en = 1'b0;
    chk("pre_rst_counter", 32'(counter), 9);
    chk("pre_rst_led", 32'(led), 32'h01FF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", 32'(main_state), 0);
    chk("async_rst_counter", 32'(counter), 0);
    chk("async_rst_led", 32'(led), 0);
    chk("async_rst_busy", 32'(busy), 0);
    step();
    rst_n = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
